fetch_unit: RTL and testbench

Instruction-fetch stage. It receives the PC redirect that execute produces (branch flag plus target pc), fetches instructions from instruction memory over a req/ack handshake, and buffers them in a small prefetch queue. Each instruction is presented to decode together with its PC+2 (the nextPC that execute consumes). Squashing, halting on HALT and decode stalls are all handled here.

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: imem req/ack fetcher feeding a prefetch queue to decode
// Handles execute redirects (with squash of an in-flight request), HALT detection and decode stalls.
module fetch_unit #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] nextPC,
  output logic        out_valid,
  output logic        halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [15:0]     r_pc;
  logic            r_squash;
  logic            r_req;
  logic [15:0]     r_addr;
  logic            r_halted;
  logic [15:0]     r_q_instr [DEPTH];
  logic [15:0]     r_q_npc   [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_valid;
  logic            w_pop;
  logic            w_ack;
  logic            w_push;
  logic            w_is_halt;
  logic            w_room;
  logic [15:0]     w_addr_inc;
  logic [CW-1:0]   w_count_next;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && !stall && !redirect;
  assign w_ack      = (r_state == S_BUSY) && imem_ack;
  // A squashed or redirect-coincident ack never reaches the queue.
  assign w_push     = w_ack && !r_squash && !redirect;
  assign w_is_halt  = (imem_rdata[15:11] == 5'b00000);
  assign w_addr_inc = r_addr + 16'd2;

  always_comb begin
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  assign w_room = (w_count_next < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_npc[r_wr_ptr]   <= w_addr_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_squash <= 1'b0;
      r_req    <= 1'b0;
      r_addr   <= 16'h0000;
      r_halted <= 1'b0;
    end else if (redirect) begin
      r_pc     <= redirect_pc;
      r_halted <= 1'b0;
      case (r_state)
        S_BUSY: begin
          if (imem_ack) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_squash <= 1'b0;
          end else begin
            // Keep the old address on the bus; its data is dropped when it lands.
            r_squash <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_room && !r_halted) begin
            r_state <= S_BUSY;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        S_BUSY: begin
          if (imem_ack) begin
            if (r_squash) begin
              r_squash <= 1'b0;
              if (w_room) begin
                r_addr <= r_pc;
              end else begin
                r_state <= S_IDLE;
                r_req   <= 1'b0;
              end
            end else begin
              r_pc <= w_addr_inc;
              if (w_is_halt) begin
                r_state  <= S_HALT;
                r_req    <= 1'b0;
                r_halted <= 1'b1;
              end else if (w_room) begin
                r_addr <= w_addr_inc;
              end else begin
                r_state <= S_IDLE;
                r_req   <= 1'b0;
              end
            end
          end
        end
        S_HALT: begin
          r_req <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign halted    = r_halted;
  assign out_valid = w_valid;
  assign instr     = w_valid ? r_q_instr[r_rd_ptr] : NOP_INSTR;
  assign nextPC    = w_valid ? r_q_npc[r_rd_ptr]   : 16'h0000;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - bench for fetch_unit: directed scenarios plus random stall/redirect/latency traffic
// The reference is the delivered instruction stream: consecutive words from the last redirect target.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [15:0] nextPC;
  logic        out_valid;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(
    .DEPTH(2),
    .RESET_PC(16'h0000),
    .NOP_INSTR(16'h0800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .nextPC(nextPC),
    .out_valid(out_valid),
    .halted(halted)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_pc = 16'h0000;
  logic [15:0] halt_addr = 16'hFFFF;
  logic [15:0] next_halt = 16'hFFFF;
  bit          halt_seen = 1'b0;
  bit          just_redir = 1'b0;
  bit          m_prev_req = 1'b0;
  bit          m_prev_ack = 1'b0;
  logic [15:0] m_prev_addr = 16'h0000;
  int          m_wait = 0;
  int          mem_lat = 0;
  bit          rand_lat = 1'b0;
  int          idle_cnt = 0;
  int          max_idle = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] word(input logic [15:0] a);
    return (a == halt_addr) ? 16'h0000 : 16'h4000 + a;
  endfunction

  // One clock cycle: memory responds, inputs are applied, the stream model advances, outputs are checked.
  task automatic step(input bit redir, input logic [15:0] rpc, input bit stl);
    bit new_req;
    bit pop;
    new_req = imem_req && (!m_prev_req || m_prev_ack);
    if (new_req) m_wait = rand_lat ? int'($urandom_range(0, 2)) : mem_lat;
    imem_ack   = imem_req && (m_wait == 0);
    imem_rdata = imem_ack ? word(imem_addr) : 16'hDEAD;
    if (imem_req && !imem_ack) m_wait--;
    m_prev_req  = imem_req;
    m_prev_ack  = imem_ack;
    m_prev_addr = imem_addr;
    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
    pop = out_valid && !stl && !redir;
    if (pop) begin
      if (exp_pc == halt_addr) begin
        check("halted_at_halt_word", 16'(halted), 16'd1);
        halt_seen = 1'b1;
      end
      exp_pc = exp_pc + 16'd2;
    end
    if (redir) begin
      exp_pc    = rpc;
      halt_seen = 1'b0;
      halt_addr = next_halt;
    end
    just_redir = redir;
    if (pop || halt_seen) idle_cnt = 0;
    else idle_cnt++;
    if (idle_cnt > max_idle) max_idle = idle_cnt;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (halt_seen) check("valid_after_halt", 16'(out_valid), 16'd0);
    if (out_valid && !halt_seen) begin
      check("head_instr", instr, word(exp_pc));
      check("head_nextpc", nextPC, exp_pc + 16'd2);
    end
    if (!out_valid) begin
      check("nop_instr", instr, NOP);
      check("nop_nextpc", nextPC, 16'h0000);
    end
    if (halted) check("req_while_halted", 16'(imem_req), 16'd0);
    if (just_redir) begin
      check("valid_after_redirect", 16'(out_valid), 16'd0);
      check("halted_after_redirect", 16'(halted), 16'd0);
    end
    if (m_prev_req && !m_prev_ack) begin
      check("req_held", 16'(imem_req), 16'd1);
      check("addr_held", imem_addr, m_prev_addr);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 16'(imem_req), 16'd0);
    check({tag, "_addr"}, imem_addr, 16'h0000);
    check({tag, "_valid"}, 16'(out_valid), 16'd0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_nextpc"}, nextPC, 16'h0000);
    check({tag, "_halted"}, 16'(halted), 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    exp_pc = 16'h0000;
    halt_seen = 1'b0;
    just_redir = 1'b0;
    halt_addr = 16'hFFFF;
    next_halt = 16'hFFFF;
    m_prev_req = 1'b0;
    m_prev_ack = 1'b0;
    m_wait = 0;
    idle_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit          stl;
    bit          redir;
    logic [15:0] rpc;

    // Zero-wait streaming after reset.
    mem_lat = 0;
    rand_lat = 1'b0;
    do_reset();
    check("first_req", 16'(imem_req), 16'd1);
    check("first_addr", imem_addr, 16'h0000);
    check("first_valid", 16'(out_valid), 16'd0);
    step(1'b0, 16'h0, 1'b0);
    check("addr_2", imem_addr, 16'h0002);
    check("valid_rise", 16'(out_valid), 16'd1);
    check("nextpc_2", nextPC, 16'h0002);
    step(1'b0, 16'h0, 1'b0);
    check("addr_4", imem_addr, 16'h0004);
    check("nextpc_4", nextPC, 16'h0004);

    // Stall fills the queue and the fetcher backs off.
    repeat (5) step(1'b0, 16'h0, 1'b1);
    check("stall_req_drop", 16'(imem_req), 16'd0);
    check("stall_hold_nextpc", nextPC, 16'h0004);
    step(1'b0, 16'h0, 1'b0);
    check("resume_req", 16'(imem_req), 16'd1);
    check("resume_addr", imem_addr, 16'h0006);

    // Redirect while a slow request to 0x0008 is outstanding.
    mem_lat = 3;
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 16'h0008); i++) step(1'b0, 16'h0, 1'b0);
    check("reach_addr_8", imem_addr, 16'h0008);
    step(1'b1, 16'h0100, 1'b0);
    for (int i = 0; i < 20 && !(imem_req && imem_addr != 16'h0008); i++) step(1'b0, 16'h0, 1'b0);
    check("squash_target", imem_addr, 16'h0100);
    check("valid_before_target", 16'(out_valid), 16'd0);

    // Redirect coincident with an ack.
    mem_lat = 0;
    repeat (4) step(1'b0, 16'h0, 1'b0);
    check("pre_coincide_req", 16'(imem_req), 16'd1);
    step(1'b1, 16'h0100, 1'b0);
    check("coincide_gap", 16'(imem_req), 16'd0);
    step(1'b0, 16'h0, 1'b0);
    check("coincide_req", 16'(imem_req), 16'd1);
    check("coincide_addr", imem_addr, 16'h0100);
    repeat (3) step(1'b0, 16'h0, 1'b0);

    // HALT word at 0x000A.
    do_reset();
    halt_addr = 16'h000A;
    for (int i = 0; i < 20 && !halted; i++) step(1'b0, 16'h0, 1'b0);
    check("halt_flag", 16'(halted), 16'd1);
    check("halt_word", instr, 16'h0000);
    check("halt_nextpc", nextPC, 16'h000C);
    repeat (4) step(1'b0, 16'h0, 1'b0);
    check("halt_drained", 16'(out_valid), 16'd0);
    check("halt_no_req", 16'(imem_req), 16'd0);
    step(1'b1, 16'h0020, 1'b0);
    check("unhalt_gap", 16'(imem_req), 16'd0);
    step(1'b0, 16'h0, 1'b0);
    check("unhalt_req", 16'(imem_req), 16'd1);
    check("unhalt_addr", imem_addr, 16'h0020);
    repeat (3) step(1'b0, 16'h0, 1'b0);

    // Wrap-around of the PC.
    step(1'b1, 16'hFFFC, 1'b0);
    repeat (6) step(1'b0, 16'h0, 1'b0);

    // Asynchronous reset mid-request.
    check("pre_async_req", 16'(imem_req), 16'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async");

    // Random traffic.
    do_reset();
    rand_lat = 1'b1;
    max_idle = 0;
    for (int i = 0; i < 3000; i++) begin
      stl   = ($urandom_range(0, 9) < 3);
      redir = ($urandom_range(0, 31) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? 16'hFFF8 : 16'($urandom_range(0, 16'h3FF) * 2);
      next_halt = ($urandom_range(0, 3) == 0) ? rpc + 16'($urandom_range(0, 6) * 2) : 16'hFFFF;
      step(redir, rpc, stl);
    end
    check("liveness", 16'(max_idle > 40), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
